// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - request/response bundle for one SRAM arbiter requester
interface sram_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter in front of the single-port instruction/data SRAM
module sram_arbiter #(
  parameter int unsigned DEPTH     = 10,
  parameter bit          PRIO_MODE = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  sram_arbiter_if.slave m0,
  sram_arbiter_if.slave m1,
  output logic         sram_req_o,
  output logic         sram_we_o,
  output logic [31:0]  sram_addr_o,
  output logic [31:0]  sram_wdata_o,
  input  logic [31:0]  sram_rdata_i
);

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_e;

  // One past the last legal byte address; 33 bits so large DEPTH cannot wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  port_e       last_q;
  port_e       rsp_port_q;
  logic        rsp_valid_q;
  logic        rsp_we_q;
  logic        rsp_err_q;

  port_e       sel_port;
  logic        gnt_any;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        acc_err;
  logic        rd_data_ok;

  // Pick the winner: lone requester wins; on conflict m1 in fixed mode, else the port not served last.
  always_comb begin
    sel_port = PORT_M0;
    if (m0.req && m1.req) begin
      sel_port = (PRIO_MODE || (last_q == PORT_M0)) ? PORT_M1 : PORT_M0;
    end else if (m1.req) begin
      sel_port = PORT_M1;
    end
  end

  // Nothing is granted while reset is held, even with requests pending.
  assign gnt_any   = rst_ni && (m0.req || m1.req);
  assign m0.gnt    = gnt_any && (sel_port == PORT_M0);
  assign m1.gnt    = gnt_any && (sel_port == PORT_M1);

  assign sel_we    = (sel_port == PORT_M1) ? m1.we    : m0.we;
  assign sel_addr  = (sel_port == PORT_M1) ? m1.addr  : m0.addr;
  assign sel_wdata = (sel_port == PORT_M1) ? m1.wdata : m0.wdata;

  // Misaligned or beyond the array: granted and acknowledged, but the SRAM never sees it.
  assign acc_err   = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= ADDR_LIMIT);

  assign sram_req_o   = gnt_any && !acc_err;
  assign sram_we_o    = sram_req_o && sel_we;
  assign sram_addr_o  = {2'b00, sel_addr[31:2]};
  assign sram_wdata_o = sel_wdata;

  // Remember who was granted so the one-cycle-late SRAM data returns to the right port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= PORT_M0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      last_q      <= PORT_M1;
    end else begin
      rsp_valid_q <= gnt_any;
      if (gnt_any) begin
        rsp_port_q <= sel_port;
        rsp_we_q   <= sel_we;
        rsp_err_q  <= acc_err;
        last_q     <= sel_port;
      end
    end
  end

  // Read data is only forwarded for an error-free read; acks and errors return zero.
  assign rd_data_ok = rsp_valid_q && !rsp_we_q && !rsp_err_q;

  assign m0.rvalid = rsp_valid_q && (rsp_port_q == PORT_M0);
  assign m1.rvalid = rsp_valid_q && (rsp_port_q == PORT_M1);
  assign m0.err    = m0.rvalid && rsp_err_q;
  assign m1.err    = m1.rvalid && rsp_err_q;
  assign m0.rdata  = (rd_data_ok && (rsp_port_q == PORT_M0)) ? sram_rdata_i : 32'h0;
  assign m1.rdata  = (rd_data_ok && (rsp_port_q == PORT_M1)) ? sram_rdata_i : 32'h0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural memory model
module tb_sram_arbiter;

  localparam int unsigned DEPTH = 10;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  sram_arbiter_if m0_if ();
  sram_arbiter_if m1_if ();
  sram_arbiter_if p0_if ();
  sram_arbiter_if p1_if ();

  logic        sram_req, sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic        p_sram_req, p_sram_we;
  logic [31:0] p_sram_addr, p_sram_wdata;
  logic [31:0] p_sram_rdata = 32'h0;

  sram_arbiter #(.DEPTH(DEPTH), .PRIO_MODE(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .m0(m0_if.slave), .m1(m1_if.slave),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  sram_arbiter #(.DEPTH(DEPTH), .PRIO_MODE(1'b1)) dut_p (
    .clk_i(clk_i), .rst_ni(rst_ni), .m0(p0_if.slave), .m1(p1_if.slave),
    .sram_req_o(p_sram_req), .sram_we_o(p_sram_we), .sram_addr_o(p_sram_addr),
    .sram_wdata_o(p_sram_wdata), .sram_rdata_i(p_sram_rdata)
  );

  // SRAM device model: synchronous write, registered read.
  logic [31:0] sram_mem [DEPTH];
  always @(posedge clk_i) begin
    if (sram_req && (sram_addr < DEPTH)) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int          ref_last;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= DEPTH * 4);
  endfunction

  // Drive one cycle of requests, check the same-cycle grant and SRAM pins, queue the response.
  task automatic do_cycle(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                          input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                          output int gp);
    logic        e_we, e_err;
    logic [31:0] e_a, e_d;
    rsp_t        r;
    @(negedge clk_i);
    #1;
    m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
    m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
    #1;
    if (r0 && r1) gp = (ref_last == 0) ? 1 : 0;
    else if (r0)  gp = 0;
    else if (r1)  gp = 1;
    else          gp = -1;
    check("m0_gnt", 32'(m0_if.gnt), 32'(gp == 0));
    check("m1_gnt", 32'(m1_if.gnt), 32'(gp == 1));
    if (gp < 0) begin
      check("sram_req_idle", 32'(sram_req), 32'h0);
    end else begin
      e_we  = (gp == 0) ? w0 : w1;
      e_a   = (gp == 0) ? a0 : a1;
      e_d   = (gp == 0) ? d0 : d1;
      e_err = addr_bad(e_a);
      check("sram_req", 32'(sram_req), 32'(!e_err));
      if (!e_err) begin
        check("sram_addr", sram_addr, e_a / 4);
        check("sram_we", 32'(sram_we), 32'(e_we));
        if (e_we) check("sram_wdata", sram_wdata, e_d);
      end
      r.port  = gp;
      r.err   = e_err;
      r.rdata = (e_err || e_we) ? 32'h0 : ref_mem[e_a / 4];
      exp_q.push_back(r);
      if (!e_err && e_we) ref_mem[e_a / 4] = e_d;
      ref_last = gp;
    end
  endtask

  // Response monitor: every queued response must appear exactly at the next falling edge.
  always @(negedge clk_i) begin
    rsp_t e;
    int   act_port;
    logic [31:0] act_rdata;
    logic act_err;
    if (m0_if.rvalid && m1_if.rvalid) begin
      n_checks++; n_fail++;
      $display("FAIL dual_rvalid actual=both expected=one");
    end
    if (m0_if.rvalid || m1_if.rvalid) begin
      act_port  = m1_if.rvalid ? 1 : 0;
      act_rdata = m1_if.rvalid ? m1_if.rdata : m0_if.rdata;
      act_err   = m1_if.rvalid ? m1_if.err : m0_if.err;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rvalid actual=port%0d expected=none", act_port);
      end else begin
        e = exp_q.pop_front();
        check("rsp_port", 32'(act_port), 32'(e.port));
        check("rsp_err", 32'(act_err), 32'(e.err));
        check("rsp_rdata", act_rdata, e.rdata);
      end
      if (act_port == 0) check("m1_idle_rdata", m1_if.rdata, 32'h0);
      else               check("m0_idle_rdata", m0_if.rdata, 32'h0);
    end else if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL missing_rvalid actual=none expected=port%0d", exp_q[0].port);
      void'(exp_q.pop_front());
    end
  end

  function automatic logic [31:0] rand_addr();
    case ($urandom % 8)
      0:       return DEPTH * 4 - 4;
      1:       return DEPTH * 4;
      2:       return 32'hFFFF_FFFC;
      3:       return ($urandom % DEPTH) * 4 + 1 + ($urandom % 3);
      default: return ($urandom % DEPTH) * 4;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int          gp;
    logic        pend0, pend1, hw0, hw1;
    logic [31:0] ha0, ha1, hd0, hd1;
    int          alt [4];

    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = 32'hA500_0000 + 32'(i);
      ref_mem[i]  = 32'hA500_0000 + 32'(i);
    end
    sram_mem[1] = 32'h0020_81b3;
    ref_mem[1]  = 32'h0020_81b3;
    sram_rdata  = 32'h0;
    ref_last    = 1;

    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h4; m0_if.wdata = 32'h0;
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h8; m1_if.wdata = 32'h0;
    p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = 32'h0; p0_if.wdata = 32'h0;
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = 32'h0; p1_if.wdata = 32'h0;

    // Reset state with requests held: nothing granted, nothing valid.
    repeat (2) @(negedge clk_i);
    check("rst_m0_gnt", 32'(m0_if.gnt), 32'h0);
    check("rst_m1_gnt", 32'(m1_if.gnt), 32'h0);
    check("rst_sram_req", 32'(sram_req), 32'h0);
    check("rst_m0_rvalid", 32'(m0_if.rvalid), 32'h0);
    check("rst_m1_err", 32'(m1_if.err), 32'h0);
    check("rst_m0_rdata", m0_if.rdata, 32'h0);
    #1;
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    rst_ni = 1'b1;

    // Round-robin: both holding reads alternates m0, m1, m0, m1 from reset.
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, gp);
      alt[i] = gp;
    end
    for (int i = 0; i < 4; i++) check("rr_order", 32'(alt[i]), 32'(i % 2));

    // Directed accesses: known read, write-then-read, boundaries and errors.
    do_cycle(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gp);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h24, 32'hDEAD_BEEF, gp);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, gp);
    do_cycle(1'b1, 1'b0, 32'h6, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gp);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h28, 32'h0, gp);
    do_cycle(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gp);
    // Read then write to the same word back-to-back: the read returns the old data.
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gp);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, gp);
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gp);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gp);

    // Randomized traffic; a losing requester holds its fields until granted.
    pend0 = 1'b0; pend1 = 1'b0;
    hw0 = 1'b0; hw1 = 1'b0; ha0 = 32'h0; ha1 = 32'h0; hd0 = 32'h0; hd1 = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0) begin
        pend0 = ($urandom % 10) < 7;
        hw0 = 1'($urandom % 2); ha0 = rand_addr(); hd0 = $urandom;
      end
      if (!pend1) begin
        pend1 = ($urandom % 10) < 7;
        hw1 = 1'($urandom % 2); ha1 = rand_addr(); hd1 = $urandom;
      end
      do_cycle(pend0, hw0, ha0, hd0, pend1, hw1, ha1, hd1, gp);
      if (gp == 0) pend0 = 1'b0;
      if (gp == 1) pend1 = 1'b0;
    end
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gp);

    // Reset during a pending response: dropped at once, never delivered.
    do_cycle(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gp);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    exp_q.delete();
    ref_last = 1;
    #1;
    check("mid_rst_m0_rvalid", 32'(m0_if.rvalid), 32'h0);
    check("mid_rst_m0_rdata", m0_if.rdata, 32'h0);
    check("mid_rst_m0_gnt", 32'(m0_if.gnt), 32'h0);
    check("mid_rst_sram_req", 32'(sram_req), 32'h0);
    @(negedge clk_i);
    #1;
    m0_if.req = 1'b0;
    rst_ni = 1'b1;
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gp);
    do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, gp);
    check("post_rst_first_winner", 32'(gp), 32'h0);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gp);

    // Fixed priority instance: m1 wins every conflict.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (i > 0) begin
        check("prio_m1_rvalid", 32'(p1_if.rvalid), 32'h1);
        check("prio_m0_rvalid", 32'(p0_if.rvalid), 32'h0);
      end
      #1;
      p0_if.req = 1'b1; p0_if.addr = 32'h0;
      p1_if.req = 1'b1; p1_if.addr = 32'h8;
      #1;
      check("prio_m1_gnt", 32'(p1_if.gnt), 32'h1);
      check("prio_m0_gnt", 32'(p0_if.gnt), 32'h0);
    end
    @(negedge clk_i);
    check("prio_m1_rvalid_last", 32'(p1_if.rvalid), 32'h1);
    #1;
    p0_if.req = 1'b0; p1_if.req = 1'b0;
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter sharing the single-port instruction/data SRAM between instruction fetch (port m0) and load/store (port m1).
- Converts byte addresses to SRAM word indices and rejects misaligned or out-of-range accesses.
- Tracks the one-cycle SRAM read latency and routes each response back to the requester that issued it.
- Sits between the core's fetch and LSU request interfaces and the SRAM's req/we/addr/wdata/rdata pins.

Parameters:
- DEPTH, 10, SRAM depth in 32-bit words; legal byte addresses are 0 to DEPTH*4-1.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, where m1 (data) always wins.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- m0_req_i / m1_req_i  input  1  request valid; held with its fields until gnt.
- m0_we_i / m1_we_i  input  1  1 = write, 0 = read.
- m0_addr_i / m1_addr_i  input  32  byte address.
- m0_wdata_i / m1_wdata_i  input  32  write data.
- m0_gnt_o / m1_gnt_o  output  1  request accepted this cycle.
- m0_rvalid_o / m1_rvalid_o  output  1  response valid, one cycle after gnt.
- m0_rdata_o / m1_rdata_o  output  32  read data; 0 when not a valid read response.
- m0_err_o / m1_err_o  output  1  access error, qualified by rvalid.
- sram_req_o  output  1  SRAM request.
- sram_we_o  output  1  SRAM write enable.
- sram_addr_o  output  32  SRAM word index, equal to {2'b00, addr[31:2]}.
- sram_wdata_o  output  32  SRAM write data.
- sram_rdata_i  input  32  SRAM read data; valid the cycle after a read request.

Behaviour:

Reset:
- rst_ni low asynchronously clears rsp_valid_q, rsp_port_q, rsp_we_q and rsp_err_q, and sets last_q = 1.
- While in reset, all gnt, rvalid, err and sram_req_o outputs are 0 and all rdata outputs are 0.
- A response pending when reset asserts is dropped and never delivered.

Arbitration (combinational, same cycle):
- Only one requester active: it is granted.
- Both active, PRIO_MODE=0: grant the port that is not last_q. last_q updates to the granted port on every grant.
- Both active, PRIO_MODE=1: grant m1.
- No requester active: no gnt, sram_req_o=0, last_q unchanged.
- Exactly one gnt is high per cycle at most. The loser keeps its request asserted with fields stable.

Access check on the granted request:
- err = (addr[1:0] != 0) or (addr >= DEPTH*4).
- err=0: sram_req_o=1; we, word address and wdata pass through to the SRAM.
- err=1: sram_req_o=0, so the SRAM is untouched. gnt is still asserted.

Response (registered, latency 1):
- On grant, at the edge: rsp_valid_q=1, rsp_port_q=granted port, rsp_we_q=we, rsp_err_q=err.
- Without a grant, at the edge: rsp_valid_q=0.
- Next cycle, only the port matching rsp_port_q sees rvalid=1 and err=rsp_err_q.
- rdata = sram_rdata_i for an error-free read; otherwise 0.
- Writes also receive rvalid, as a write acknowledgement.

Throughput:
- One grant per cycle, back-to-back, with no bubbles.
- A new grant may coincide with the previous response.
- A write granted in the cycle a read response to the same address is delivered does not affect that response; the old data is returned.

Boundaries:
- Address DEPTH*4-4 is legal.
- Address DEPTH*4 is an error.
- Address 0xFFFF_FFFC is an error, with no wrap-around.
- Misaligned error has priority only as an error flag; there is no partial access.

Test Plan:
- Reset, then m0 reads addr 0x4 -> m0_gnt_o=1 same cycle; sram_addr_o=1; next cycle m0_rvalid_o=1, m0_rdata_o=0x002081b3, m0_err_o=0; m1 outputs stay 0.
- m1 writes 0xDEADBEEF to addr 0x24, then m1 reads 0x24 -> write ack rvalid with rdata 0, then read returns 0xDEADBEEF.
- PRIO_MODE=0, both ports hold read requests for 4 cycles -> grants alternate m0, m1, m0, m1; each rvalid lands on the matching port one cycle after its gnt.
- PRIO_MODE=1, both ports requesting for 3 cycles -> m1 granted every cycle; m0_gnt_o stays 0.
- m0 reads addr 0x6 (misaligned), then m1 reads 0x28 (DEPTH=10) -> each gnt, sram_req_o=0; next cycle rvalid=1, err=1, rdata=0.
- m0 read granted, then rst_ni pulled low mid-cycle before the response edge -> m0_rvalid_o=0 immediately and no response after release; the first conflict after reset is granted to m0.
